// File: rtl/param_shift_engine_pkg.sv
// Shared types for the shift engine: shift modes, FSM states and a min helper.
// Imported by the interface, the step datapath and the top level.
package shift_pkg;

   typedef enum logic [2:0] {
      SH_LSL = 3'd0,
      SH_LSR = 3'd1,
      SH_ROL = 3'd2,
      SH_ROR = 3'd3,
      SH_ASR = 3'd4
   } sh_mode_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } st_e;

   function automatic int unsigned min_u(input int unsigned a,
                                         input int unsigned b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/param_shift_engine_if.sv
// Command/status bundle of the shift engine.
// master drives load/start/mode/amt/din; slave returns busy/done/dout.
interface param_shift_engine_if #(
   parameter int WIDTH = 16,
   parameter int AMT_W = $clog2(WIDTH) + 1
);
   logic             i_load;
   logic [WIDTH-1:0] din;
   logic             i_start;
   logic [2:0]       i_mode;
   logic [AMT_W-1:0] i_amt;
   logic             o_busy;
   logic             o_done;
   logic [WIDTH-1:0] dout;

   modport master (
      output i_load, din, i_start, i_mode, i_amt,
      input  o_busy, o_done, dout
   );

   modport slave (
      input  i_load, din, i_start, i_mode, i_amt,
      output o_busy, o_done, dout
   );
endinterface

// File: rtl/param_shift_engine_shift_step.sv
// One combinational shift step: v shifted by amt (0..STEP) in the given mode.
// Ports: v, mode, amt in; y out. Reserved modes pass v through.
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int AMT_W = $clog2(WIDTH) + 1
) (
   input  logic [WIDTH-1:0] v,
   input  logic [2:0]       mode,
   input  logic [AMT_W-1:0] amt,
   output logic [WIDTH-1:0] y
);

   // Rotations shift a doubled copy so amt==WIDTH needs no special case.
   logic [2*WIDTH-1:0] dbl;
   logic [2*WIDTH-1:0] rol_t;
   logic [2*WIDTH-1:0] ror_t;

   always_comb begin
      dbl   = {v, v};
      rol_t = dbl << amt;
      ror_t = dbl >> amt;
      y     = v;
      case (mode)
         SH_LSL:  y = v << amt;
         SH_LSR:  y = v >> amt;
         SH_ROL:  y = rol_t[2*WIDTH-1:WIDTH];
         SH_ROR:  y = ror_t[WIDTH-1:0];
         SH_ASR:  y = WIDTH'($signed(v) >>> amt);
         default: y = v;
      endcase
   end

endmodule

// File: rtl/param_shift_engine.sv
// Loadable register that shifts by a programmable amount, STEP bits per clock.
// Ports: i_clk, i_rst_n, bus (load/start/mode/amt/din in, busy/done/dout out).
module param_shift_engine
   import shift_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int STEP  = 1,
   parameter int AMT_W = $clog2(WIDTH) + 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   param_shift_engine_if.slave  bus
);

   st_e              state, nxt_state;
   logic [AMT_W-1:0] cnt, nxt_cnt;
   logic [2:0]       mode_q, nxt_mode;
   logic [WIDTH-1:0] dout_q, nxt_dout;
   logic             done_q, nxt_done;
   logic [AMT_W-1:0] s;
   logic [WIDTH-1:0] step_y;

   // Last step may be shorter than STEP.
   assign s = AMT_W'(min_u(STEP, 32'(cnt)));

   shift_step #(
      .WIDTH (WIDTH),
      .AMT_W (AMT_W)
   ) u_step (
      .v    (dout_q),
      .mode (mode_q),
      .amt  (s),
      .y    (step_y)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         mode_q <= '0;
         dout_q <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= nxt_state;
         cnt    <= nxt_cnt;
         mode_q <= nxt_mode;
         dout_q <= nxt_dout;
         done_q <= nxt_done;
      end
   end

   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_mode  = mode_q;
      nxt_dout  = dout_q;
      nxt_done  = 1'b0;
      if (bus.i_load) begin
         // Load wins everywhere and silently aborts a running shift.
         nxt_dout  = bus.din;
         nxt_state = ST_IDLE;
         nxt_cnt   = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.i_start) begin
                  if (bus.i_amt != '0) begin
                     nxt_mode  = bus.i_mode;
                     nxt_cnt   = bus.i_amt;
                     nxt_state = ST_SHIFT;
                  end else begin
                     nxt_done = 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               nxt_dout = step_y;
               nxt_cnt  = cnt - s;
               if (cnt == s) begin
                  nxt_state = ST_IDLE;
                  nxt_done  = 1'b1;
               end
            end
            default: nxt_state = ST_IDLE;
         endcase
      end
   end

   assign bus.o_busy = (state == ST_SHIFT);
   assign bus.o_done = done_q;
   assign bus.dout   = dout_q;

endmodule

// File: tb/tb_param_shift_engine.sv
// Directed bench for param_shift_engine with STEP=1 and STEP=4 instances.
// Expected values are hand computed; all checks go through chk.
module tb_param_shift_engine;

   localparam int W = 16;
   localparam int A = $clog2(W) + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   param_shift_engine_if #(.WIDTH(W), .AMT_W(A)) b1 ();
   param_shift_engine_if #(.WIDTH(W), .AMT_W(A)) b4 ();

   param_shift_engine #(.WIDTH(W), .STEP(1), .AMT_W(A)) u1 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (b1)
   );

   param_shift_engine #(.WIDTH(W), .STEP(4), .AMT_W(A)) u4 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (b4)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic busy(input bit s4);
      return s4 ? b4.o_busy : b1.o_busy;
   endfunction

   function automatic logic done(input bit s4);
      return s4 ? b4.o_done : b1.o_done;
   endfunction

   function automatic logic [W-1:0] dout(input bit s4);
      return s4 ? b4.dout : b1.dout;
   endfunction

   task automatic drive(input bit s4, input logic ld, input logic [W-1:0] d,
                        input logic st, input logic [2:0] m,
                        input logic [A-1:0] amt);
      if (s4) begin
         b4.i_load = ld; b4.din = d; b4.i_start = st;
         b4.i_mode = m;  b4.i_amt = amt;
      end else begin
         b1.i_load = ld; b1.din = d; b1.i_start = st;
         b1.i_mode = m;  b1.i_amt = amt;
      end
   endtask

   task automatic load(input bit s4, input logic [W-1:0] d);
      drive(s4, 1'b1, d, 1'b0, 3'd0, '0);
      tick();
      drive(s4, 1'b0, '0, 1'b0, 3'd0, '0);
   endtask

   // Start an operation and follow it until busy drops (bounded).
   task automatic run_op(input bit s4, input logic [2:0] m,
                         input logic [A-1:0] amt, input int exp_cyc,
                         input logic [W-1:0] exp_d, input string tag);
      int cyc;
      drive(s4, 1'b0, '0, 1'b1, m, amt);
      tick();
      drive(s4, 1'b0, '0, 1'b0, 3'd0, '0);
      cyc = 0;
      while (busy(s4) && cyc < 200) begin
         if (done(s4)) chk({tag, "_early_done"}, 32'(done(s4)), 32'd0);
         cyc++;
         tick();
      end
      chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, "_done"}, 32'(done(s4)), 32'd1);
      chk({tag, "_dout"}, 32'(dout(s4)), 32'(exp_d));
   endtask

   initial begin
      drive(1'b0, 1'b0, '0, 1'b0, 3'd0, '0);
      drive(1'b1, 1'b0, '0, 1'b0, 3'd0, '0);
      #12 rst_n = 1'b1;
      tick();

      // Async reset from a non-zero register, mid-cycle.
      load(1'b0, 16'hFFFF);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_dout", 32'(b1.dout), 32'd0);
      chk("rst_busy", 32'(b1.o_busy), 32'd0);
      chk("rst_done", 32'(b1.o_done), 32'd0);
      #3 rst_n = 1'b1;
      tick();

      load(1'b0, 16'hA5C3);
      chk("load_dout", 32'(b1.dout), 32'h0000A5C3);
      chk("load_busy", 32'(b1.o_busy), 32'd0);

      // LSL 4 with single done pulse.
      load(1'b0, 16'h00F1);
      run_op(1'b0, 3'd0, 5'd4, 4, 16'h0F10, "lsl4");
      tick();
      chk("lsl4_pulse", 32'(b1.o_done), 32'd0);

      load(1'b0, 16'h8010);
      run_op(1'b0, 3'd4, 5'd3, 3, 16'hF002, "asr3");
      load(1'b0, 16'h1234);
      run_op(1'b0, 3'd3, 5'd20, 20, 16'h4123, "ror20");

      // STEP=4 instance.
      load(1'b1, 16'h1234);
      run_op(1'b1, 3'd2, 5'd10, 3, 16'hD048, "s4_rol10");
      load(1'b1, 16'hBEEF);
      run_op(1'b1, 3'd1, 5'd16, 4, 16'h0000, "s4_lsr16");
      load(1'b1, 16'h8001);
      run_op(1'b1, 3'd4, 5'd16, 4, 16'hFFFF, "s4_asr16");

      // Abort with load on the third shift cycle.
      load(1'b0, 16'h00FF);
      drive(1'b0, 1'b0, '0, 1'b1, 3'd0, 5'd8);
      tick();
      drive(1'b0, 1'b0, '0, 1'b0, 3'd0, '0);
      tick();
      tick();
      drive(1'b0, 1'b1, 16'h5555, 1'b0, 3'd0, '0);
      tick();
      drive(1'b0, 1'b0, '0, 1'b0, 3'd0, '0);
      chk("abort_dout", 32'(b1.dout), 32'h00005555);
      chk("abort_busy", 32'(b1.o_busy), 32'd0);
      chk("abort_done", 32'(b1.o_done), 32'd0);
      tick();
      chk("abort_done2", 32'(b1.o_done), 32'd0);

      // Load and start together: load wins.
      drive(1'b0, 1'b1, 16'h1111, 1'b1, 3'd0, 5'd3);
      tick();
      drive(1'b0, 1'b0, '0, 1'b0, 3'd0, '0);
      chk("ldst_dout", 32'(b1.dout), 32'h00001111);
      chk("ldst_busy", 32'(b1.o_busy), 32'd0);
      tick();
      chk("ldst_busy2", 32'(b1.o_busy), 32'd0);
      chk("ldst_done", 32'(b1.o_done), 32'd0);

      // Zero amount.
      run_op(1'b0, 3'd0, 5'd0, 0, 16'h1111, "amt0");

      // Start during SHIFT is ignored.
      load(1'b0, 16'h0001);
      drive(1'b0, 1'b0, '0, 1'b1, 3'd0, 5'd2);
      tick();
      drive(1'b0, 1'b0, '0, 1'b1, 3'd1, 5'd7);
      tick();
      drive(1'b0, 1'b0, '0, 1'b0, 3'd0, '0);
      tick();
      chk("ign_busy", 32'(b1.o_busy), 32'd0);
      chk("ign_done", 32'(b1.o_done), 32'd1);
      chk("ign_dout", 32'(b1.dout), 32'h00000004);
      tick();
      chk("ign_idle", 32'(b1.o_busy), 32'd0);

      // Back-to-back: second start lands in the done cycle.
      run_op(1'b0, 3'd0, 5'd1, 1, 16'h0008, "b2b_a");
      run_op(1'b0, 3'd2, 5'd4, 4, 16'h0080, "b2b_b");

      // Reserved mode holds dout but runs the full count.
      run_op(1'b0, 3'd6, 5'd5, 5, 16'h0080, "rsv6");

      // Reset mid-operation leaves the block idle.
      drive(1'b0, 1'b0, '0, 1'b1, 3'd0, 5'd9);
      tick();
      drive(1'b0, 1'b0, '0, 1'b0, 3'd0, '0);
      tick();
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      chk("rst_mid_busy", 32'(b1.o_busy), 32'd0);
      chk("rst_mid_dout", 32'(b1.dout), 32'd0);
      tick();
      chk("rst_mid_done", 32'(b1.o_done), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/param_shift_engine.md
# param_shift_engine

Parametrised, multi-mode, multi-cycle shift register and the next generation of the team's fixed 16-bit load/shift-left register. It loads a WIDTH-bit word, then on command shifts it by a programmable amount in one of five modes (logical, rotate, arithmetic), at up to STEP bit positions per clock. A busy/done handshake lets a controlling FSM sequence it. It sits in the shifter library beside the fixed-width registers.

## Interface
- WIDTH, 16: data width; ≥ 2.
- STEP, 1: maximum bit positions shifted per clock; 1 ≤ STEP ≤ WIDTH.
- AMT_W, $clog2(WIDTH)+1: width of the shift-amount field. Amount WIDTH is representable.
- i_clk  in  1  rising-edge clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_load  in  1  load din into the register.
- din  in  WIDTH  parallel load data.
- i_start  in  1  begin a shift operation.
- i_mode  in  3  shift mode, sampled with i_start.
- i_amt  in  AMT_W  total shift distance, sampled with i_start.
- o_busy  out  1  shift operation in progress.
- o_done  out  1  one-cycle pulse when an operation completes.
- dout  out  WIDTH  register contents.

## Operation
- Modes:
  - 0 LSL: shift left, fill with 0.
  - 1 LSR: shift right, fill with 0.
  - 2 ROL: rotate left.
  - 3 ROR: rotate right.
  - 4 ASR: shift right, fill with dout[WIDTH-1].
  - 5–7 reserved: the operation runs normally but dout is held.
- FSM has two states, IDLE and SHIFT. Internal state: cnt (AMT_W bits), mode_q (3 bits).
- IDLE behaviour:
  - i_load=1: dout ← din.
  - Otherwise, i_start=1 and i_amt≠0: mode_q ← i_mode, cnt ← i_amt, go to SHIFT.
  - Otherwise, i_start=1 and i_amt=0: dout is unchanged and o_done pulses on the next cycle.
- SHIFT behaviour, each cycle:
  - s = min(STEP, cnt).
  - dout ← shift(dout, mode_q, s); cnt ← cnt − s.
  - When cnt reaches 0: return to IDLE and assert o_done for one cycle.
- Amounts ≥ WIDTH:
  - LSL/LSR give all zeros.
  - ASR gives all copies of the sign bit.
  - ROL/ROR give the rotation by (amt mod WIDTH). This falls out naturally from the stepwise rotation.
- Priority and boundaries:
  - i_load has priority over i_start in every state.
  - i_load during SHIFT aborts the operation: dout ← din, FSM → IDLE, cnt ← 0, no o_done.
  - i_start during SHIFT is ignored. i_mode and i_amt are don't-care outside the i_start cycle in IDLE.
  - i_start in the same cycle that o_done is high is accepted, because the FSM is in IDLE then. This allows back-to-back operations.
- Reset (i_rst_n low, asynchronous): dout=0, o_busy=0, o_done=0, state IDLE, cnt=0, mode_q=0.
  - Deassertion mid-operation leaves the block idle. Nothing resumes.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- o_busy = (state == SHIFT). It rises on the edge that accepts i_start.
- Latency for a start accepted at edge k with amount N:
  - Final dout appears at edge k + ceil(N/STEP).
  - o_done is high during the cycle after that edge, coincident with o_busy falling.
  - For N=0: o_done is high in the cycle after edge k and o_busy never rises.
- A load takes effect at the next edge: dout = din one cycle later.

## Structure
- Package shift_pkg holds:
  - the mode enum (SH_LSL, SH_LSR, SH_ROL, SH_ROR, SH_ASR);
  - the state enum (ST_IDLE, ST_SHIFT);
  - a min helper function.
- One combinational sub-module, shift_step. Inputs: WIDTH-bit value, mode, and amount 0..STEP. Output: the shifted value. It implements all five modes; reserved modes pass the value through.
- The top level holds the FSM, the counter and the registers, and instantiates shift_step once.

## Test plan
- Reset and load: assert i_rst_n=0 mid-cycle → all outputs 0 immediately. Then load din=16'hA5C3 → dout=16'hA5C3 on the next edge, o_busy=0.
- LSL by 4, STEP=1: from 16'h00F1 → o_busy high for 4 cycles, dout=16'h0F10, o_done pulses once together with o_busy falling.
- ASR by 3 and ROR by 20, STEP=1: ASR of 16'h8010 → 16'hF002. ROR by 20 of 16'h1234 → 16'h4123.
- STEP=4, WIDTH=16, ROL by 10: 16'h1234 → 16'hD048 after 3 shift cycles (steps of 4, 4, 2). LSR by 16 → 16'h0000 after 4 cycles.
- Abort and priority: start LSL by 8, assert i_load with din=16'h5555 on cycle 3 → dout=16'h5555, FSM idle, no o_done. Assert i_start with i_load in the same cycle → load wins, no operation starts.
- Edge cases:
  - i_amt=0 → o_done the next cycle, dout unchanged, o_busy stays 0.
  - i_start during SHIFT → ignored.
  - Back-to-back start in the o_done cycle → accepted.
  - Reserved mode 6 with amount 5 → 5 busy cycles, dout held.
